taglist_builder: RTL and testbench

- Upstream stage of the sequence player. After `start`, it scans the sample ROM word by word and finds tag marker words.
- For each tagged sequence it writes one packed taglist entry (tag, start address, end address, last flag) into the taglist RAM write port. The ROM_state sequencer later reads these entries.
- Replaces hand-loading of the taglist; the whole table is built automatically after power-up or a ROM change.

---
 rtl/taglist_builder.sv | 221 ++++++++++++++++++++++
 tb/tb_taglist_builder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/taglist_builder.sv
// Scans the sample ROM for tag marker words and writes one packed taglist entry per tagged sequence.
// Optional: define TAGLIST_CLEAR_EN to zero all 128 taglist RAM entries before every scan.
module taglist_builder #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 10,
  parameter int                ROM_LAT  = 2,
  parameter logic [DATA_W-1:0] SENTINEL = 16'hFFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              taglist_wr,
  output logic [6:0]        taglist_addr,
  output logic [31:0]       taglist_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        entry_count
);

  localparam int                PEND_W     = ADDR_W + 1;
  localparam logic [7:0]        FLUSH_LAST = (ROM_LAT > 1) ? 8'(ROM_LAT - 2) : 8'd0;
  localparam logic [ADDR_W-1:0] TOP_ADDR   = '1;
  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
  localparam logic [PEND_W-1:0] ONE_P      = PEND_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FLUSH,
    FINAL,
    DONE
`ifdef TAGLIST_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_romAddr;
  logic                r_issue;
  logic [ROM_LAT-1:0]  r_pipeVld;
  logic [ADDR_W-1:0]   r_pipeAddr [ROM_LAT];
  logic                r_pendVld;
  logic [6:0]          r_pendTag;
  logic [PEND_W-1:0]   r_pendStart;
  logic [PEND_W-1:0]   r_endAddr;
  logic [7:0]          r_count;
  logic                r_ovf;
  logic [7:0]          r_flushCnt;
  logic                r_wr;
  logic [6:0]          r_wAddr;
  logic [31:0]         r_wData;
`ifdef TAGLIST_CLEAR_EN
  logic [6:0]          r_clrIdx;
`endif

  logic                w_wordValid;
  logic                w_isSent;
  logic                w_isMark;
  logic                w_atTop;
  logic                w_stop;
  logic                w_markTry;
  logic                w_finalTry;
  logic                w_full;
  logic [ADDR_W-1:0]   w_wordAddr;
  logic [ADDR_W-1:0]   w_prevAddr;
  logic [PEND_W-1:0]   w_wordAddrX;

  // The last pipe stage carries the address of the word currently on rom_q.
  assign w_wordAddr  = r_pipeAddr[ROM_LAT-1];
  assign w_prevAddr  = w_wordAddr - ONE_A;
  assign w_wordAddrX = {1'b0, w_wordAddr};
  assign w_wordValid = (r_state == SCAN) && r_pipeVld[ROM_LAT-1];
  assign w_isSent    = (rom_q == SENTINEL);
  assign w_isMark    = !w_isSent && rom_q[DATA_W-1];
  assign w_atTop     = (w_wordAddr == TOP_ADDR);
  assign w_stop      = w_wordValid && (w_isSent || w_atTop);
  assign w_markTry   = w_wordValid && w_isMark && r_pendVld && (r_pendStart < w_wordAddrX);
  assign w_finalTry  = (r_state == FINAL) && r_pendVld && (r_pendStart <= r_endAddr);
  assign w_full      = r_count[7];

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
`ifdef TAGLIST_CLEAR_EN
          w_next = CLEAR;
`else
          w_next = SCAN;
`endif
        end
      end
`ifdef TAGLIST_CLEAR_EN
      CLEAR: if (r_clrIdx == 7'd127) w_next = SCAN;
`endif
      SCAN:  if ((w_markTry && w_full) || w_stop) w_next = FLUSH;
      FLUSH: if (r_flushCnt == FLUSH_LAST) w_next = r_ovf ? DONE : FINAL;
      FINAL: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_romAddr   <= '0;
      r_issue     <= 1'b0;
      r_pipeVld   <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_pipeAddr[i] <= '0;
      r_pendVld   <= 1'b0;
      r_pendTag   <= '0;
      r_pendStart <= '0;
      r_endAddr   <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_flushCnt  <= '0;
      r_wr        <= 1'b0;
      r_wAddr     <= '0;
      r_wData     <= '0;
`ifdef TAGLIST_CLEAR_EN
      r_clrIdx    <= '0;
`endif
    end else begin
      r_wr          <= 1'b0;
      r_pipeVld[0]  <= r_issue;
      r_pipeAddr[0] <= r_romAddr;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pipeVld[i]  <= r_pipeVld[i-1];
        r_pipeAddr[i] <= r_pipeAddr[i-1];
      end

      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_romAddr <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_pendVld <= 1'b0;
`ifdef TAGLIST_CLEAR_EN
            r_clrIdx  <= '0;
`else
            r_issue   <= 1'b1;
`endif
          end
        end
`ifdef TAGLIST_CLEAR_EN
        CLEAR: begin
          r_wr     <= 1'b1;
          r_wAddr  <= r_clrIdx;
          r_wData  <= '0;
          r_clrIdx <= r_clrIdx + 7'd1;
          if (r_clrIdx == 7'd127) begin
            r_romAddr <= '0;
            r_issue   <= 1'b1;
          end
        end
`endif
        SCAN: begin
          // Addresses stop at the top of the ROM instead of wrapping back to 0.
          if (r_issue) begin
            if (r_romAddr == TOP_ADDR) r_issue   <= 1'b0;
            else                       r_romAddr <= r_romAddr + ONE_A;
          end
          if (w_markTry) begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_wr    <= 1'b1;
              r_wAddr <= r_count[6:0];
              r_wData <= {4'b0, r_pendTag, r_pendStart[ADDR_W-1:0], w_prevAddr, 1'b0};
              r_count <= r_count + 8'd1;
            end
          end
          if (w_wordValid && w_isMark) begin
            r_pendVld   <= 1'b1;
            r_pendTag   <= rom_q[6:0];
            r_pendStart <= w_wordAddrX + ONE_P;
          end
          if (w_stop) r_endAddr <= w_isSent ? (w_wordAddrX - ONE_P) : w_wordAddrX;
          if (w_next != SCAN) begin
            r_issue    <= 1'b0;
            r_pipeVld  <= '0;
            r_flushCnt <= '0;
          end
        end
        FLUSH: r_flushCnt <= r_flushCnt + 8'd1;
        FINAL: begin
          if (w_finalTry) begin
            if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_wr    <= 1'b1;
              r_wAddr <= r_count[6:0];
              r_wData <= {4'b0, r_pendTag, r_pendStart[ADDR_W-1:0], r_endAddr[ADDR_W-1:0], 1'b1};
              r_count <= r_count + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr     = r_romAddr;
  assign taglist_wr   = r_wr;
  assign taglist_addr = r_wAddr;
  assign taglist_data = r_wData;
  assign busy         = (r_state != IDLE) && (r_state != DONE);
  assign done         = (r_state == DONE);
  assign overflow     = r_ovf;
  assign entry_count  = r_count;

endmodule

// File: tb/tb_taglist_builder.sv
// Directed testbench for taglist_builder with a 2-cycle-latency ROM model and write capture.
module tb_taglist_builder;

`ifdef TAGLIST_CLEAR_EN
  localparam int CLR = 128;
`else
  localparam int CLR = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  rom_addr;
  logic [15:0] rom_q = 16'h0000;
  logic        taglist_wr;
  logic [6:0]  taglist_addr;
  logic [31:0] taglist_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [7:0]  entry_count;

  logic [15:0] rom [0:1023];
  logic [9:0]  romAddrQ = '0;

  logic [6:0]  capAddr [0:299];
  logic [31:0] capData [0:299];
  int          capN;
  int          maxAddr;
  int          errors = 0;
  int          checks = 0;

  taglist_builder dut (
    .clock(clock), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .taglist_wr(taglist_wr), .taglist_addr(taglist_addr), .taglist_data(taglist_data),
    .busy(busy), .done(done), .overflow(overflow), .entry_count(entry_count)
  );

  always #5 clock = ~clock;

  // Registered address plus registered output gives two cycles of read latency.
  always @(posedge clock) begin
    romAddrQ <= rom_addr;
    rom_q    <= rom[romAddrQ];
  end

  function automatic logic [31:0] pack(input int tag, input int s, input int e, input bit last);
    return {4'b0, 7'(tag), 10'(s), 10'(e), last};
  endfunction

  task automatic clearRom;
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
  endtask

  task automatic loadBasic;
    clearRom();
    rom[0]  = 16'h8001;
    rom[6]  = 16'h8002;
    rom[13] = 16'hFFFF;
  endtask

  // Pulses start, then records every write until done rises or the budget runs out.
  task automatic runScan(input int budget, input bit poke, output bit timedOut);
    int n;
    capN = 0; maxAddr = 0; timedOut = 1'b0; n = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    forever begin
      if (taglist_wr === 1'b1 && capN < 300) begin
        capAddr[capN] = taglist_addr;
        capData[capN] = taglist_data;
        capN++;
      end
      if (int'(rom_addr) > maxAddr) maxAddr = int'(rom_addr);
      if (done === 1'b1) break;
      if (n >= budget) begin timedOut = 1'b1; break; end
      @(negedge clock);
      n++;
      start = (poke && (n == 3 || n == 9)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (taglist_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %b expected 0", taglist_wr); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (entry_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", entry_count); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy_done: got %b%b expected 00", busy, done); end
  endtask

  task automatic test_basic;
    bit to;
    loadBasic();
    runScan(400, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: got %b expected 0", to); end
    checks++; if (capN !== CLR + 2) begin errors++; $display("[TB] FAIL basic_nwrites: got %0d expected %0d", capN, CLR + 2); end
    checks++; if (capAddr[CLR] !== 7'd0 || capData[CLR] !== pack(1, 1, 5, 0)) begin errors++; $display("[TB] FAIL basic_entry0: got %0d:%h expected 0:%h", capAddr[CLR], capData[CLR], pack(1, 1, 5, 0)); end
    checks++; if (capAddr[CLR+1] !== 7'd1 || capData[CLR+1] !== pack(2, 7, 12, 1)) begin errors++; $display("[TB] FAIL basic_entry1: got %0d:%h expected 1:%h", capAddr[CLR+1], capData[CLR+1], pack(2, 7, 12, 1)); end
    checks++; if (entry_count !== 8'd2) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 2", entry_count); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_busy: got %b%b expected 10", done, busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL basic_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_adjacent_markers;
    bit to;
    clearRom();
    rom[0] = 16'h8001; rom[1] = 16'h8002; rom[2] = 16'h8003; rom[5] = 16'hFFFF;
    runScan(400, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL adj_timeout: got %b expected 0", to); end
    checks++; if (capN !== CLR + 1) begin errors++; $display("[TB] FAIL adj_nwrites: got %0d expected %0d", capN, CLR + 1); end
    checks++; if (capAddr[CLR] !== 7'd0 || capData[CLR] !== pack(3, 3, 4, 1)) begin errors++; $display("[TB] FAIL adj_entry0: got %0d:%h expected 0:%h", capAddr[CLR], capData[CLR], pack(3, 3, 4, 1)); end
    checks++; if (entry_count !== 8'd1) begin errors++; $display("[TB] FAIL adj_count: got %0d expected 1", entry_count); end
  endtask

  task automatic test_no_sentinel;
    bit to;
    clearRom();
    rom[1000] = 16'h8005;
    runScan(1500, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL top_timeout: got %b expected 0", to); end
    checks++; if (capN !== CLR + 1) begin errors++; $display("[TB] FAIL top_nwrites: got %0d expected %0d", capN, CLR + 1); end
    checks++; if (capData[CLR] !== pack(5, 1001, 1023, 1)) begin errors++; $display("[TB] FAIL top_entry0: got %h expected %h", capData[CLR], pack(5, 1001, 1023, 1)); end
    checks++; if (maxAddr !== 1023) begin errors++; $display("[TB] FAIL top_max_addr: got %0d expected 1023", maxAddr); end
    checks++; if (rom_addr !== 10'd1023) begin errors++; $display("[TB] FAIL top_rom_addr_hold: got %0d expected 1023", rom_addr); end
  endtask

  task automatic test_overflow;
    bit to;
    clearRom();
    for (int k = 0; k <= 128; k++) rom[2*k] = 16'h8000 | 16'((k + 1) % 128);
    rom[258] = 16'hFFFF;
    runScan(800, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL ovf_timeout: got %b expected 0", to); end
    checks++; if (capN !== CLR + 128) begin errors++; $display("[TB] FAIL ovf_nwrites: got %0d expected %0d", capN, CLR + 128); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (entry_count !== 8'd128) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 128", entry_count); end
    checks++; if (capData[CLR] !== pack(1, 1, 1, 0)) begin errors++; $display("[TB] FAIL ovf_entry0: got %h expected %h", capData[CLR], pack(1, 1, 1, 0)); end
    checks++; if (capAddr[CLR+127] !== 7'd127 || capData[CLR+127] !== pack(0, 255, 255, 0)) begin errors++; $display("[TB] FAIL ovf_entry127: got %0d:%h expected 127:%h", capAddr[CLR+127], capData[CLR+127], pack(0, 255, 255, 0)); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done: got %b expected 1", done); end
  endtask

  task automatic test_no_marker;
    bit to;
    clearRom();
    rom[20] = 16'hFFFF;
    runScan(400, 1'b0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL nomark_timeout: got %b expected 0", to); end
    checks++; if (capN !== CLR) begin errors++; $display("[TB] FAIL nomark_nwrites: got %0d expected %0d", capN, CLR); end
    checks++; if (entry_count !== 8'd0) begin errors++; $display("[TB] FAIL nomark_count: got %0d expected 0", entry_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL nomark_overflow_cleared: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid_scan;
    bit to;
    int n;
    loadBasic();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (rom_addr !== 10'd3 && n < 300) begin @(negedge clock); n++; end
    checks++; if (n >= 300) begin errors++; $display("[TB] FAIL rst_reach_addr3: got %0d cycles expected <300", n); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (taglist_wr !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr: got %b expected 0", taglist_wr); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle: got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("[TB] FAIL rst_rom_addr: got %0d expected 0", rom_addr); end
    reset = 1'b0;
    runScan(400, 1'b0, to);
    checks++; if (to !== 1'b0 || capN !== CLR + 2) begin errors++; $display("[TB] FAIL rst_rescan_nwrites: got %0d (timeout %b) expected %0d", capN, to, CLR + 2); end
    checks++; if (capData[CLR] !== pack(1, 1, 5, 0) || capData[CLR+1] !== pack(2, 7, 12, 1)) begin errors++; $display("[TB] FAIL rst_rescan_entries: got %h %h expected %h %h", capData[CLR], capData[CLR+1], pack(1, 1, 5, 0), pack(2, 7, 12, 1)); end
  endtask

  task automatic test_start_while_busy;
    bit to;
    loadBasic();
    runScan(400, 1'b1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL busy_timeout: got %b expected 0", to); end
    checks++; if (capN !== CLR + 2) begin errors++; $display("[TB] FAIL busy_nwrites: got %0d expected %0d", capN, CLR + 2); end
    checks++; if (capData[CLR] !== pack(1, 1, 5, 0) || capData[CLR+1] !== pack(2, 7, 12, 1)) begin errors++; $display("[TB] FAIL busy_entries: got %h %h expected %h %h", capData[CLR], capData[CLR+1], pack(1, 1, 5, 0), pack(2, 7, 12, 1)); end
    checks++; if (entry_count !== 8'd2) begin errors++; $display("[TB] FAIL busy_count: got %0d expected 2", entry_count); end
`ifdef TAGLIST_CLEAR_EN
    checks++; if (capAddr[127] !== 7'd127 || capData[127] !== 32'h0) begin errors++; $display("[TB] FAIL clear_last: got %0d:%h expected 127:0", capAddr[127], capData[127]); end
`endif
  endtask

  initial begin
    clearRom();
    test_reset();
    test_basic();
    test_adjacent_markers();
    test_no_sentinel();
    test_overflow();
    test_no_marker();
    test_reset_mid_scan();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
